// File: rtl/qspis_pkg.sv
// Shared definitions for the quad-SPI slave to Wishbone bridge:
// state encodings, opcodes, phase lengths and the bus request payload.
package qspis_pkg;

  localparam int unsigned NIB_W    = 4;
  localparam int unsigned WORD_W   = 32;
  localparam int unsigned BITCNT_W = 6;
  localparam int unsigned SEL_W    = 4;

  localparam int unsigned CMD_BITS   = 8;
  localparam int unsigned ADDR_BITS  = 32;
  localparam int unsigned WDATA_BITS = 32;
  localparam int unsigned DUMMY_BITS = 16;
  localparam int unsigned RDATA_BITS = 32;

  localparam logic [7:0] OP_WR = 8'h02;
  localparam logic [7:0] OP_RD = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WDATA  = 3'd3,
    ST_DUMMY  = 3'd4,
    ST_RDATA  = 3'd5,
    ST_IGNORE = 3'd6
  } spi_state_e;

  typedef struct packed {
    logic              we;
    logic [WORD_W-1:0] adr;
    logic [WORD_W-1:0] dat;
  } wb_req_t;

  // True when the nibble arriving now is the last one of a phase of len bits.
  function automatic logic last_nibble(input logic [BITCNT_W-1:0] cnt,
                                       input int unsigned len);
    return cnt == BITCNT_W'(len - NIB_W);
  endfunction

endpackage

// File: rtl/qspis_sync.sv
// Brings sclk/ssn/sdin into the sys_clk domain and flags sclk edges and ssn fall.
// Flops preset to bus idle levels so leaving reset never fakes an edge.
module qspis_sync
  import qspis_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             ssn,
  input  logic [NIB_W-1:0] sdin,
  output logic             sclk_rise_c,
  output logic             sclk_fall_c,
  output logic             ssn_fall_c,
  output logic             ssn_level,
  output logic [NIB_W-1:0] sdin_level
);

  logic [SYNC_STAGES-1:0]            sclk_q;
  logic [SYNC_STAGES-1:0]            ssn_q;
  logic [SYNC_STAGES-1:0][NIB_W-1:0] sdin_q;
  logic                              sclk_d;
  logic                              ssn_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= '0;
      ssn_q  <= '1;
      sdin_q <= '0;
      sclk_d <= 1'b0;
      ssn_d  <= 1'b1;
    end else begin
      sclk_q[0] <= sclk;
      ssn_q[0]  <= ssn;
      sdin_q[0] <= sdin;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sclk_q[i] <= sclk_q[i-1];
        ssn_q[i]  <= ssn_q[i-1];
        sdin_q[i] <= sdin_q[i-1];
      end
      sclk_d <= sclk_q[SYNC_STAGES-1];
      ssn_d  <= ssn_q[SYNC_STAGES-1];
    end
  end

  assign sclk_rise_c = sclk_q[SYNC_STAGES-1] & ~sclk_d;
  assign sclk_fall_c = ~sclk_q[SYNC_STAGES-1] & sclk_d;
  assign ssn_fall_c  = ~ssn_q[SYNC_STAGES-1] & ssn_d;
  assign ssn_level   = ssn_q[SYNC_STAGES-1];
  assign sdin_level  = sdin_q[SYNC_STAGES-1];

endmodule

// File: rtl/qspis_top.sv
// Quad-SPI (mode 0) slave that turns write/read frames into single
// Wishbone word transfers; all logic runs on sys_clk.
module qspis_top
  import qspis_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                ssn,
  input  logic [NIB_W-1:0]    sdin,
  output logic [NIB_W-1:0]    sdout,
  output logic                sdout_oen,
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic [WORD_W-1:0]   wbm_adr_o,
  output logic                wbm_we_o,
  output logic [WORD_W-1:0]   wbm_dat_o,
  output logic [SEL_W-1:0]    wbm_sel_o,
  input  logic [WORD_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i,
  output logic [2:0]          spi_if_st,
  output logic                sck_toggle,
  output logic [BITCNT_W-1:0] bitcnt,
  output logic                inst_trg,
  output logic                addr_trg,
  output logic                spi_st_trans,
  output logic                spi_trig
);

  logic             sclk_rise_c;
  logic             sclk_fall_c;
  logic             ssn_fall_c;
  logic             ssn_s;
  logic [NIB_W-1:0] sdin_s;

  spi_state_e              state;
  spi_state_e              state_next;
  logic [WORD_W-NIB_W-1:0] shift_reg;
  logic [WORD_W-1:0]       rx_word_c;
  logic [7:0]              opcode_c;
  logic [WORD_W-1:0]       addr_q;
  logic [WORD_W-1:0]       tx_word;
  logic [WORD_W-1:0]       rd_data;
  logic                    rd_valid;
  logic                    is_read;
  logic                    cmd_done_c;
  logic                    addr_done_c;
  logic                    wdata_done_c;
  logic                    launch_c;
  wb_req_t                 req_c;

  qspis_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clk     (sys_clk),
    .rst_n       (rst_n),
    .sclk        (sclk),
    .ssn         (ssn),
    .sdin        (sdin),
    .sclk_rise_c (sclk_rise_c),
    .sclk_fall_c (sclk_fall_c),
    .ssn_fall_c  (ssn_fall_c),
    .ssn_level   (ssn_s),
    .sdin_level  (sdin_s)
  );

  // Word including the nibble being sampled right now.
  assign rx_word_c = {shift_reg, sdin_s};
  assign opcode_c  = rx_word_c[7:0];
  assign spi_if_st = state;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    cmd_done_c   = 1'b0;
    addr_done_c  = 1'b0;
    wdata_done_c = 1'b0;
    if (state != ST_IDLE && ssn_s) begin
      state_next = ST_IDLE;
    end else if (state == ST_IDLE) begin
      if (ssn_fall_c) state_next = ST_CMD;
    end else if (sclk_rise_c) begin
      case (state)
        ST_CMD: if (last_nibble(bitcnt, CMD_BITS)) begin
          cmd_done_c = 1'b1;
          state_next = (opcode_c == OP_WR || opcode_c == OP_RD) ? ST_ADDR : ST_IGNORE;
        end
        ST_ADDR: if (last_nibble(bitcnt, ADDR_BITS)) begin
          addr_done_c = 1'b1;
          state_next  = is_read ? ST_DUMMY : ST_WDATA;
        end
        ST_WDATA: if (last_nibble(bitcnt, WDATA_BITS)) begin
          wdata_done_c = 1'b1;
          state_next   = ST_IGNORE;
        end
        ST_DUMMY: if (last_nibble(bitcnt, DUMMY_BITS)) state_next = ST_RDATA;
        ST_RDATA: if (last_nibble(bitcnt, RDATA_BITS)) state_next = ST_IGNORE;
        default: ;
      endcase
    end
  end

  // Bus request launched at the end of the address (read) or data (write) phase.
  always_comb begin
    launch_c = (addr_done_c && is_read) || wdata_done_c;
    req_c.we  = wdata_done_c;
    req_c.adr = wdata_done_c ? addr_q : rx_word_c;
    req_c.dat = wdata_done_c ? rx_word_c : '0;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg    <= '0;
      addr_q       <= '0;
      is_read      <= 1'b0;
      tx_word      <= '0;
      sdout        <= '0;
      sdout_oen    <= 1'b1;
      bitcnt       <= '0;
      sck_toggle   <= 1'b0;
      inst_trg     <= 1'b0;
      addr_trg     <= 1'b0;
      spi_st_trans <= 1'b0;
      spi_trig     <= 1'b0;
    end else begin
      if (state_next != state || state == ST_IDLE) bitcnt <= '0;
      else if (sclk_rise_c)                        bitcnt <= bitcnt + BITCNT_W'(NIB_W);

      if (sclk_rise_c) sck_toggle <= ~sck_toggle;
      inst_trg     <= cmd_done_c;
      addr_trg     <= addr_done_c;
      spi_st_trans <= (state_next != state);
      if (ssn_fall_c) spi_trig <= 1'b1;
      else if (ssn_s) spi_trig <= 1'b0;

      if (sclk_rise_c && state inside {ST_CMD, ST_ADDR, ST_WDATA, ST_DUMMY})
        shift_reg <= rx_word_c[WORD_W-NIB_W-1:0];
      if (cmd_done_c)  is_read <= (opcode_c == OP_RD);
      if (addr_done_c) addr_q  <= rx_word_c;

      // First nibble is presented on RDATA entry; the fall that follows the
      // last dummy rise is skipped via bitcnt so nibbles line up with rises.
      if (state == ST_DUMMY && state_next == ST_RDATA) begin
        tx_word <= rd_valid ? {rd_data[WORD_W-NIB_W-1:0], NIB_W'(0)} : '0;
        sdout   <= rd_valid ? rd_data[WORD_W-1 -: NIB_W] : '0;
      end else if (state_next != ST_RDATA) begin
        tx_word <= '0;
        sdout   <= '0;
      end else if (sclk_fall_c && bitcnt != '0) begin
        sdout   <= tx_word[WORD_W-1 -: NIB_W];
        tx_word <= tx_word << NIB_W;
      end
      sdout_oen <= (state_next != ST_RDATA);
    end
  end

  // Wishbone master: a launched cycle runs to ack/err regardless of ssn.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbm_sel_o <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
    end else if (wbm_cyc_o) begin
      if (wbm_ack_i || wbm_err_i) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_adr_o <= '0;
        wbm_dat_o <= '0;
        wbm_sel_o <= '0;
        if (!wbm_we_o) begin
          rd_data  <= wbm_ack_i ? wbm_dat_i : '0;
          rd_valid <= 1'b1;
        end
      end
    end else if (launch_c) begin
      wbm_cyc_o <= 1'b1;
      wbm_stb_o <= 1'b1;
      wbm_we_o  <= req_c.we;
      wbm_adr_o <= req_c.adr;
      wbm_dat_o <= req_c.dat;
      wbm_sel_o <= '1;
      if (!req_c.we) rd_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_qspis_top.sv
// Directed bench for qspis_top: quad-SPI master tasks, a one-word-per-slot
// Wishbone memory that acks (or errors) one cycle after a request.
module tb_qspis_top;

  logic        sys_clk;
  logic        rst_n;
  logic        sclk;
  logic        ssn;
  logic [3:0]  sdin;
  logic [3:0]  sdout;
  logic        sdout_oen;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [31:0] wbm_adr_o;
  logic        wbm_we_o;
  logic [31:0] wbm_dat_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_dat_i = 32'h0;
  logic        wbm_ack_i = 1'b0;
  logic        wbm_err_i = 1'b0;
  logic [2:0]  spi_if_st;
  logic        sck_toggle;
  logic [5:0]  bitcnt;
  logic        inst_trg;
  logic        addr_trg;
  logic        spi_st_trans;
  logic        spi_trig;

  int checks = 0;
  int errors = 0;

  logic        err_mode;
  int          wb_cyc_cnt = 0;
  logic [31:0] last_adr = 32'h0;
  logic [31:0] last_dat = 32'h0;
  logic [3:0]  last_sel = 4'h0;
  logic        last_we  = 1'b0;
  logic [31:0] mem [16] = '{default: 32'h0};

  int inst_cnt = 0;
  int addr_cnt = 0;
  int trans_cnt = 0;
  int oen_low_cnt = 0;

  qspis_top #(.SYNC_STAGES(2)) dut (
    .sys_clk      (sys_clk),
    .rst_n        (rst_n),
    .sclk         (sclk),
    .ssn          (ssn),
    .sdin         (sdin),
    .sdout        (sdout),
    .sdout_oen    (sdout_oen),
    .wbm_cyc_o    (wbm_cyc_o),
    .wbm_stb_o    (wbm_stb_o),
    .wbm_adr_o    (wbm_adr_o),
    .wbm_we_o     (wbm_we_o),
    .wbm_dat_o    (wbm_dat_o),
    .wbm_sel_o    (wbm_sel_o),
    .wbm_dat_i    (wbm_dat_i),
    .wbm_ack_i    (wbm_ack_i),
    .wbm_err_i    (wbm_err_i),
    .spi_if_st    (spi_if_st),
    .sck_toggle   (sck_toggle),
    .bitcnt       (bitcnt),
    .inst_trg     (inst_trg),
    .addr_trg     (addr_trg),
    .spi_st_trans (spi_st_trans),
    .spi_trig     (spi_trig)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Wishbone slave memory: responds one cycle after seeing a request.
  always begin
    @(posedge sys_clk);
    #1;
    if (wbm_cyc_o && wbm_stb_o && !wbm_ack_i && !wbm_err_i) begin
      wb_cyc_cnt++;
      last_adr = wbm_adr_o;
      last_dat = wbm_dat_o;
      last_sel = wbm_sel_o;
      last_we  = wbm_we_o;
      if (err_mode) begin
        wbm_err_i = 1'b1;
        wbm_dat_i = 32'hFFFF_FFFF;
      end else begin
        wbm_ack_i = 1'b1;
        if (wbm_we_o) mem[wbm_adr_o[5:2]] = wbm_dat_o;
        else          wbm_dat_i = mem[wbm_adr_o[5:2]];
      end
    end else begin
      wbm_ack_i = 1'b0;
      wbm_err_i = 1'b0;
      wbm_dat_i = 32'h0;
    end
  end

  always @(negedge sys_clk) begin
    if (inst_trg)     inst_cnt++;
    if (addr_trg)     addr_cnt++;
    if (spi_st_trans) trans_cnt++;
    if (!sdout_oen)   oen_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    sdin = n;
    #80 sclk = 1'b1;
    #80 sclk = 1'b0;
  endtask

  task automatic tx_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic tx_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) nib(w[i*4 +: 4]);
  endtask

  // Samples sdout just before each rise, as a mode-0 master would.
  task automatic rx_word(output logic [31:0] w, output int oen_ok);
    w = 32'h0;
    oen_ok = 0;
    for (int i = 0; i < 8; i++) begin
      sdin = 4'h0;
      #80;
      w = {w[27:0], sdout};
      if (!sdout_oen) oen_ok++;
      sclk = 1'b1;
      #80 sclk = 1'b0;
    end
  endtask

  task automatic sel_lo;
    ssn = 1'b0;
    #160;
  endtask

  task automatic sel_hi;
    #80 ssn = 1'b1;
    #240;
  endtask

  initial begin
    int          s_wb;
    int          s_inst;
    int          s_addr;
    int          s_tr;
    int          s_oen;
    int          oen_ok;
    logic [31:0] rd;

    rst_n = 1'b0;
    ssn = 1'b1;
    sclk = 1'b0;
    sdin = 4'h0;
    err_mode = 1'b0;
    #22;
    check("rst_state", 32'(spi_if_st), 32'd0);
    check("rst_bitcnt", 32'(bitcnt), 32'd0);
    check("rst_sdout", 32'(sdout), 32'd0);
    check("rst_oen", 32'(sdout_oen), 32'd1);
    check("rst_wb_ctl", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
    check("rst_wb_adr", wbm_adr_o, 32'd0);
    check("rst_wb_dat", wbm_dat_o, 32'd0);
    check("rst_debug", 32'({sck_toggle, inst_trg, addr_trg, spi_st_trans, spi_trig}), 32'd0);
    #30 rst_n = 1'b1;
    #100;
    check("post_rst_state", 32'(spi_if_st), 32'd0);
    check("post_rst_toggle", 32'(sck_toggle), 32'd0);

    // Write 0x02 @0x10 <- DEADBEEF
    s_wb = wb_cyc_cnt; s_inst = inst_cnt; s_addr = addr_cnt; s_tr = trans_cnt;
    sel_lo;
    check("wr_trig", 32'(spi_trig), 32'd1);
    check("wr_cmd_state", 32'(spi_if_st), 32'd1);
    tx_byte(8'h02);
    check("wr_addr_state", 32'(spi_if_st), 32'd2);
    check("wr_addr_bitcnt", 32'(bitcnt), 32'd0);
    tx_word(32'h0000_0010);
    check("wr_wdata_state", 32'(spi_if_st), 32'd3);
    tx_word(32'hDEAD_BEEF);
    check("wr_ignore_state", 32'(spi_if_st), 32'd6);
    check("wr_oen", 32'(sdout_oen), 32'd1);
    sel_hi;
    check("wr_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd1);
    check("wr_wb_adr", last_adr, 32'h0000_0010);
    check("wr_wb_dat", last_dat, 32'hDEAD_BEEF);
    check("wr_wb_sel", 32'(last_sel), 32'hF);
    check("wr_wb_we", 32'(last_we), 32'd1);
    check("wr_inst_pulses", 32'(inst_cnt - s_inst), 32'd1);
    check("wr_addr_pulses", 32'(addr_cnt - s_addr), 32'd1);
    check("wr_transitions", 32'(trans_cnt - s_tr), 32'd5);
    check("wr_idle_state", 32'(spi_if_st), 32'd0);
    check("wr_trig_low", 32'(spi_trig), 32'd0);
    check("wr_cyc_end", 32'(wbm_cyc_o), 32'd0);

    // Read 0x0B @0x10
    s_wb = wb_cyc_cnt;
    sel_lo;
    tx_byte(8'h0B);
    tx_word(32'h0000_0010);
    check("rd_dummy_state", 32'(spi_if_st), 32'd4);
    check("rd_dummy_oen", 32'(sdout_oen), 32'd1);
    for (int i = 0; i < 4; i++) nib(4'h0);
    check("rd_rdata_state", 32'(spi_if_st), 32'd5);
    check("rd_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd1);
    check("rd_wb_we", 32'(last_we), 32'd0);
    check("rd_wb_adr", last_adr, 32'h0000_0010);
    rx_word(rd, oen_ok);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_oen_samples", 32'(oen_ok), 32'd8);
    check("rd_end_state", 32'(spi_if_st), 32'd6);
    check("rd_end_oen", 32'(sdout_oen), 32'd1);
    check("rd_end_sdout", 32'(sdout), 32'd0);
    sel_hi;

    // Unknown opcode 0x9F
    s_wb = wb_cyc_cnt; s_oen = oen_low_cnt;
    sel_lo;
    tx_byte(8'h9F);
    check("op9f_state", 32'(spi_if_st), 32'd6);
    tx_word(32'h1234_5678);
    tx_word(32'h0000_0000);
    check("op9f_state_late", 32'(spi_if_st), 32'd6);
    sel_hi;
    check("op9f_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd0);
    check("op9f_oen_low", 32'(oen_low_cnt - s_oen), 32'd0);
    check("op9f_idle", 32'(spi_if_st), 32'd0);

    // Abort after four address nibbles, then a clean write
    s_wb = wb_cyc_cnt;
    sel_lo;
    tx_byte(8'h02);
    nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4);
    check("abort_bitcnt", 32'(bitcnt), 32'd16);
    check("abort_addr_state", 32'(spi_if_st), 32'd2);
    sel_hi;
    check("abort_idle", 32'(spi_if_st), 32'd0);
    check("abort_bitcnt_clr", 32'(bitcnt), 32'd0);
    check("abort_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd0);
    sel_lo;
    tx_byte(8'h02);
    tx_word(32'h0000_0020);
    tx_word(32'h1234_5678);
    sel_hi;
    check("after_abort_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd1);
    check("after_abort_adr", last_adr, 32'h0000_0020);
    check("after_abort_dat", last_dat, 32'h1234_5678);

    // Read terminated by err
    err_mode = 1'b1;
    s_wb = wb_cyc_cnt;
    sel_lo;
    tx_byte(8'h0B);
    tx_word(32'h0000_0010);
    for (int i = 0; i < 4; i++) nib(4'h0);
    check("err_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd1);
    check("err_cyc_end", 32'(wbm_cyc_o), 32'd0);
    rx_word(rd, oen_ok);
    check("err_rd_data", rd, 32'h0000_0000);
    check("err_oen_samples", 32'(oen_ok), 32'd8);
    sel_hi;
    err_mode = 1'b0;

    // Reset in the middle of write data
    s_wb = wb_cyc_cnt;
    sel_lo;
    tx_byte(8'h02);
    tx_word(32'h0000_0030);
    nib(4'hC); nib(4'hA); nib(4'hF);
    check("mid_wdata_state", 32'(spi_if_st), 32'd3);
    check("mid_wdata_bitcnt", 32'(bitcnt), 32'd12);
    rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(spi_if_st), 32'd0);
    check("midrst_bitcnt", 32'(bitcnt), 32'd0);
    check("midrst_sdout", 32'({sdout_oen, sdout}), 32'h10);
    check("midrst_wb", 32'({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}), 32'd0);
    check("midrst_debug", 32'({sck_toggle, inst_trg, addr_trg, spi_st_trans, spi_trig}), 32'd0);
    ssn = 1'b1;
    #49 rst_n = 1'b1;
    #100;
    sel_lo;
    tx_byte(8'h02);
    tx_word(32'h0000_0030);
    tx_word(32'hCAFE_F00D);
    sel_hi;
    check("postrst_wb_count", 32'(wb_cyc_cnt - s_wb), 32'd1);
    check("postrst_adr", last_adr, 32'h0000_0030);
    check("postrst_dat", last_dat, 32'hCAFE_F00D);
    sel_lo;
    tx_byte(8'h0B);
    tx_word(32'h0000_0030);
    for (int i = 0; i < 4; i++) nib(4'h0);
    rx_word(rd, oen_ok);
    check("postrst_rd_data", rd, 32'hCAFE_F00D);
    sel_hi;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspis_top.md
QSPIS_TOP -- requirements
Module: qspis_top

Interface
REQ-001 Parameter: SYNC_STAGES, default 2, number of sys_clk flops synchronising sclk, ssn and sdin.
REQ-002 sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assertion, active-low.
REQ-004 sclk  in  1  QSPI clock from the master, SPI mode 0, frequency <= sys_clk/8.
REQ-005 ssn  in  1  slave select, active-low.
REQ-006 sdin  in  4  quad data in; nibble MSB first.
REQ-007 sdout  out  4  quad data out.
REQ-008 sdout_oen  out  1  output enable, active-low: 0 = slave drives the pads.
REQ-009 wbm_cyc_o, wbm_stb_o  out  1 each  Wishbone cycle and strobe.
REQ-010 wbm_adr_o  out  32  byte address; wbm_we_o  out  1; wbm_dat_o  out  32; wbm_sel_o  out  4.
REQ-011 wbm_dat_i  in  32; wbm_ack_i  in  1; wbm_err_i  in  1.
REQ-012 Debug outputs: spi_if_st out 3, sck_toggle out 1, bitcnt out 6, inst_trg out 1, addr_trg out 1, spi_st_trans out 1, spi_trig out 1.

Function
REQ-013 Edge detection: sclk rise and fall are detected from synchronised samples; all shifting runs on sys_clk.
REQ-014 Frame format, all phases quad:
- command: 8 bits, 2 sclk
- address: 32 bits, 8 sclk
- then per command
- 4 bits are sampled on each sclk rise; the first nibble is bits [n:n-3].
REQ-015 States (spi_if_st):
- IDLE=0, CMD=1, ADDR=2, WDATA=3, DUMMY=4, RDATA=5, IGNORE=6
- ssn fall: IDLE->CMD.
REQ-016 CMD->ADDR after 8 bits when the opcode is 0x02 (write) or 0x0B (read); any other opcode -> IGNORE.
REQ-017 After 32 address bits: write -> WDATA; read -> DUMMY, and a Wishbone read is launched at once.
REQ-018 WDATA: after 32 bits, a Wishbone write of the assembled word is launched; the state then goes to IGNORE.
REQ-019 DUMMY lasts 4 sclk (16 bits); the state then goes to RDATA.
REQ-020 RDATA:
- sdout_oen=0
- the latched read word shifts out MSB nibble first, updated on each sclk fall
- the first nibble is valid before the first RDATA rise
- after 8 sclk the state goes to IGNORE.
REQ-021 ssn high in any state returns to IDLE within SYNC_STAGES+1 cycles, sets sdout_oen=1 and clears bitcnt.
REQ-022 bitcnt counts bits received in the current phase (+4 per sclk rise) and clears on each phase change.
REQ-023 Wishbone:
- cyc=stb=1 held until ack or err
- wbm_sel_o=4'hF
- dat_i captured on ack
- err terminates the cycle and returns read data 0
- a cycle already launched always completes, even if ssn rises.
REQ-024 If the read ack has not arrived by the first RDATA nibble, 0 is shifted out.
REQ-025 Debug pulses, each one sys_clk wide:
- inst_trg: on command byte complete
- addr_trg: on address complete
- spi_st_trans: on any spi_if_st change.
REQ-026 Debug levels:
- sck_toggle toggles on every detected sclk rise
- spi_trig is 1 from the synchronised ssn fall to the ssn rise.
REQ-027 Idle output values:
- sdout=0 when not driving; sdout_oen=1 outside RDATA
- all wbm_* outputs are 0 when no Wishbone cycle is active.

Reset
REQ-028 rst_n low asynchronously forces:
- state IDLE, all shift registers 0, bitcnt 0
- sdout 0, sdout_oen 1
- all Wishbone outputs 0, all debug outputs 0.
REQ-029 Leaving reset: the synchroniser is preset to idle levels (sclk=0, ssn=1), so no false edge is detected on the first cycle.

Structure
REQ-030 A shared package holds the state encodings, opcodes WR=0x02 and RD=0x0B, and the phase bit lengths 8/32/32/16/32.
REQ-031 One sub-module, qspis_sync, performs synchronisation and sclk rise/fall detection.

Verification
REQ-032 Write 0x02, addr 0x0000_0010, data 0xDEAD_BEEF -> exactly one WB write: adr 0x10, dat 0xDEADBEEF, sel 0xF, we=1; inst_trg and addr_trg each pulse once.
REQ-033 Read 0x0B, addr 0x10 after that write, memory ack 1 cycle later -> 16 dummy bits, then nibbles D,E,A,D,B,E,E,F on sdout with sdout_oen=0.
REQ-034 Opcode 0x9F -> spi_if_st=6; no WB cycle; sdout_oen stays 1 to ssn rise.
REQ-035 ssn raised after 4 address nibbles -> return to IDLE, no WB cycle; the next frame decodes correctly.
REQ-036 Read with wbm_err_i instead of ack -> data 0x00000000 shifted out; the WB cycle ends.
REQ-037 rst_n pulsed low mid-WDATA -> all outputs at reset values immediately; the next write frame succeeds.
